// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl
//   Debug controller that gates a CPU clock enable. It supports free run,
//   single-instruction step and run-to-breakpoint. It records the PC of every
//   instruction started into a show-ahead trace FIFO, and it counts the
//   instructions started and the enabled cycles.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   mode[1:0]            00 run, 01/11 step, 10 run-with-breakpoint
//   step_req             single-instruction request (honoured in HALT)
//   bp_en, bp_addr       breakpoint enable and PC (mode 10 only)
//   pc, curstate         CPU program counter and control state
//   cpu_ce               CPU clock enable (combinational)
//   halted               high while halted or in reset
//   trace_rd             pop oldest trace entry
//   trace_dout           oldest trace entry, 0 when empty
//   trace_empty/full     FIFO status; trace_ovf sticky overflow
//   instr_cnt, cyc_cnt   instructions started, cycles with cpu_ce=1
module cpu_debug_ctrl #(
  parameter int PC_W        = 8,
  parameter int STATE_W     = 3,
  parameter int FETCH_STATE = 0,
  parameter int DEPTH       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               step_req,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic [STATE_W-1:0] curstate,
  output logic               cpu_ce,
  output logic               halted,
  input  logic               trace_rd,
  output logic [PC_W-1:0]    trace_dout,
  output logic               trace_empty,
  output logic               trace_full,
  output logic               trace_ovf,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        cyc_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

  state_t            state_q, state_d;
  logic              armed;
  logic              boundary, push, pop, wr;
  logic [PC_W-1:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;

  assign boundary = (curstate == STATE_W'(FETCH_STATE));

  // armed doubles as the "entry boundary already executed" marker in STEP.
  // Both are cleared on leaving HALT and set by the first enabled boundary.
  always_comb begin
    state_d = state_q;
    cpu_ce  = 1'b0;
    unique case (state_q)
      HALT: begin
        if (mode == 2'b00 || mode == 2'b10) state_d = RUN;
        else if (step_req)                  state_d = STEP;
      end
      RUN: begin
        if (boundary && (mode[0] ||
            (mode == 2'b10 && bp_en && pc == bp_addr && armed)))
          state_d = HALT;
        else
          cpu_ce = 1'b1;
      end
      STEP: begin
        if (boundary && armed) state_d = HALT;
        else                   cpu_ce  = 1'b1;
      end
      default: state_d = HALT;
    endcase
    if (rst) cpu_ce = 1'b0;
  end

  assign push        = boundary && cpu_ce;
  assign trace_empty = (cnt == '0);
  assign trace_full  = (cnt == (AW+1)'(DEPTH));
  assign pop         = trace_rd && !trace_empty;
  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign wr          = push && (!trace_full || pop);

  assign halted     = rst || (state_q == HALT);
  assign trace_dout = (rst || trace_empty) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HALT;
      armed     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      trace_ovf <= 1'b0;
      instr_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HALT && state_d != HALT) armed <= 1'b0;
      else if (push)                          armed <= 1'b1;

      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (!wr && pop) cnt <= cnt - (AW+1)'(1);
      if (push && !wr) trace_ovf <= 1'b1;

      if (push)   instr_cnt <= instr_cnt + 32'd1;
      if (cpu_ce) cyc_cnt   <= cyc_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= pc;
  end

endmodule

// File: doc/cpu_debug_ctrl.md
CPU_DEBUG_CTRL -- requirements
Module: cpu_debug_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning the CPU PC width.
REQ-002 The block SHALL have parameter STATE_W, default 3, meaning the CPU curstate width.
REQ-003 The block SHALL have parameter FETCH_STATE, default 0, meaning the curstate encoding of the instruction-fetch state.
REQ-004 The block SHALL have parameter DEPTH, default 16, meaning trace FIFO entries (power of 2, >=2).
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 mode  in  2  00 run, 01 step, 10 run-with-breakpoint, 11 treated as 01.
REQ-008 step_req  in  1  single-instruction request, sampled in HALT only.
REQ-009 bp_en  in  1  breakpoint enable (mode 10 only).
REQ-010 bp_addr  in  PC_W  breakpoint PC.
REQ-011 pc  in  PC_W  CPU program counter.
REQ-012 curstate  in  STATE_W  CPU control state.
REQ-013 cpu_ce  out  1  CPU clock enable, combinational from registered state and inputs.
REQ-014 halted  out  1  high in HALT.
REQ-015 trace_rd  in  1  pop oldest trace entry.
REQ-016 trace_dout  out  PC_W  oldest trace entry (show-ahead), 0 when empty.
REQ-017 trace_empty  out  1; trace_full  out  1; trace_ovf  out  1 sticky overflow flag.
REQ-018 instr_cnt  out  32  instructions started; cyc_cnt  out  32  cycles with cpu_ce=1.

Function
REQ-019 FSM states SHALL be HALT, RUN, STEP; boundary cycle = cycle with curstate==FETCH_STATE.
REQ-020 HALT: cpu_ce=0; mode 00 or 10 -> RUN next cycle; else step_req=1 -> STEP next cycle; else stay.
REQ-021 RUN: cpu_ce=1 except on a stop boundary, where cpu_ce=0 in that same cycle and the FSM enters HALT.
REQ-022 Stop boundary in RUN SHALL be: mode 01/11, or mode 10 with bp_en=1, pc==bp_addr and breakpoint armed.
REQ-023 Breakpoint SHALL be disarmed on every HALT exit and re-armed after the first boundary cycle with cpu_ce=1, so resuming from a breakpoint executes that instruction.
REQ-024 STEP: cpu_ce=1 on entry boundary; on the next boundary cycle cpu_ce=0 and the FSM enters HALT (exactly one instruction executes).
REQ-025 Mode changes in STEP SHALL be ignored until HALT is reached.
REQ-026 Every boundary cycle with cpu_ce=1 SHALL push pc into the trace FIFO and increment instr_cnt.
REQ-027 cyc_cnt SHALL increment on every cycle with cpu_ce=1; both counters wrap 2^32-1 -> 0.
REQ-028 Push when full SHALL be dropped and set trace_ovf, which stays high until reset.
REQ-029 Simultaneous push and pop when full SHALL accept both; count unchanged, no overflow.
REQ-030 Pop when empty SHALL be ignored; simultaneous push and pop when empty SHALL push only.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; full when count==DEPTH.

Reset
REQ-032 On rst=1 at an edge: FSM=HALT, armed=0, FIFO cleared, trace_empty=1, trace_full=0, trace_ovf=0, instr_cnt=0, cyc_cnt=0.
REQ-033 During and after reset until the FSM leaves HALT: cpu_ce=0, halted=1, trace_dout=0.
REQ-034 Reset mid-RUN or mid-STEP SHALL take priority over all other events in that cycle.

Verification
REQ-035 Reset, mode=00, CPU model cycling curstate 0,1,2,0 with pc+1 per instruction from 0 -> cpu_ce=1 from cycle 1, trace holds 0,1,2,..., instr_cnt increments every 3 cycles.
REQ-036 Mode 10, bp_en=1, bp_addr=5 -> halt with cpu_ce=0 on boundary pc=5, instr_cnt=5; switching mode 00->10 again -> pc 5 executes, no re-break until pc=5 recurs.
REQ-037 Mode 01, three step_req pulses from HALT -> exactly 3 instructions, trace 0,1,2, halted=1 between steps, cyc_cnt=9.
REQ-038 DEPTH=16, run 20 instructions without reads -> trace_full=1, trace_ovf=1, trace holds pc 0..15; pop with push while full -> count stays 16, trace_ovf unchanged.
REQ-039 rst asserted mid-STEP (curstate=1) -> next cycle HALT, trace_empty=1, counters 0, cpu_ce=0.
REQ-040 trace_rd on empty FIFO -> no state change, trace_dout=0, trace_empty=1.
